tx_fifo_ctrl: RTL and testbench

//  Pointer/flag controller that turns the dual-port TX buffer memory into a FIFO.

---
 rtl/tx_fifo_ctrl_if.sv | 40 ++++
 rtl/tx_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_tx_fifo_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tx_fifo_ctrl_if.sv
// tx_fifo_ctrl_if: request/strobe/status bundle between the TX FIFO
// controller (slave side), its requesters and the buffer memory (master side).
// Optional error flags ovf/unf exist only when TX_FIFO_ERR_EN is defined.
interface tx_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef TX_FIFO_ERR_EN
    logic                  ovf;
    logic                  unf;
`endif

    // controller side
    modport slave (
        input  push, pop, flush,
        output mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty, count
`ifdef TX_FIFO_ERR_EN
        , output ovf, unf
`endif
    );

    // requester / memory side
    modport master (
        output push, pop, flush,
        input  mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty, count
`ifdef TX_FIFO_ERR_EN
        , input ovf, unf
`endif
    );
endinterface

// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: pointer/flag controller turning a dual-port buffer memory
// into a FIFO. Drives the memory write port from accepted pushes and the read
// port from accepted pops; rd_valid marks the cycle the popped word appears.
// Optional feature macro: TX_FIFO_ERR_EN adds sticky ovf/unf error flags.
module tx_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    tx_fifo_ctrl_if.slave bus
);
    localparam int unsigned       DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ZERO_CNT = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0]   ONE_CNT  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_PTR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

    // The data word itself never passes through this block; DATA_WIDTH only
    // documents the memory word size. Degenerate widths elaborate to nothing.
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_params
    end

    logic [ADDR_WIDTH-1:0] wptr_r;
    logic [ADDR_WIDTH-1:0] rptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  rd_valid_r;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic                  push_acc_s;
    logic                  pop_acc_s;
    logic                  full_s;
    logic                  empty_s;

    // Acceptance decisions and next occupancy; flush overrides both requests.
    always_comb begin
        full_s      = (count_r == FULL_CNT);
        empty_s     = (count_r == ZERO_CNT);
        pop_acc_s   = bus.pop & ~empty_s & ~bus.flush;
        // A push into a full FIFO fits only because the same-cycle pop frees
        // the slot; the memory reads the old word before it is overwritten.
        push_acc_s  = bus.push & (~full_s | pop_acc_s) & ~bus.flush;
        count_nxt_s = count_r;
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_nxt_s = count_r + ONE_CNT;
            2'b01:   count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and read-valid state; pointers wrap modulo depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_r     <= ZERO_PTR;
            rptr_r     <= ZERO_PTR;
            count_r    <= ZERO_CNT;
            rd_valid_r <= 1'b0;
        end else if (bus.flush) begin
            wptr_r     <= ZERO_PTR;
            rptr_r     <= ZERO_PTR;
            count_r    <= ZERO_CNT;
            rd_valid_r <= 1'b0;
        end else begin
            wptr_r     <= push_acc_s ? wptr_r + ONE_PTR : wptr_r;
            rptr_r     <= pop_acc_s  ? rptr_r + ONE_PTR : rptr_r;
            count_r    <= count_nxt_s;
            rd_valid_r <= pop_acc_s;
        end
    end

    assign bus.mem_we    = push_acc_s;
    assign bus.mem_re    = pop_acc_s;
    assign bus.mem_waddr = wptr_r;
    assign bus.mem_raddr = rptr_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
    assign bus.count     = count_r;

`ifdef TX_FIFO_ERR_EN
    logic ovf_r;
    logic unf_r;

    // Sticky error flags: set by rejected requests, cleared only by flush/reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (bus.flush) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (bus.push & ~push_acc_s);
            unf_r <= unf_r | (bus.pop  & ~pop_acc_s);
        end
    end

    assign bus.ovf = ovf_r;
    assign bus.unf = unf_r;
`endif
endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// tb_tx_fifo_ctrl: directed + random stimulus against a queue-based FIFO
// model; a behavioural dual-port memory sits on the controller's strobes.
module tb_tx_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] mem [DEPTH];

    tx_fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    tx_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural buffer memory: write port addr1, registered read port addr2.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= wdata;
        if (bus.mem_re) rdata <= mem[bus.mem_raddr];
    end

    // Reference model state
    logic [31:0] q [$];
    int          n_push;
    int          n_pop;
    logic        exp_rv;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic        exp_unf;

    int tests;
    int failed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
        chk("waddr", 32'(bus.mem_waddr), 32'(n_push % DEPTH));
        chk("raddr", 32'(bus.mem_raddr), 32'(n_pop % DEPTH));
        if (exp_rv) chk("rdata", rdata, exp_data);
`ifdef TX_FIFO_ERR_EN
        chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
        chk("unf", 32'(bus.unf), 32'(exp_unf));
`endif
    endtask

    task automatic reset_model();
        q.delete();
        n_push  = 0;
        n_pop   = 0;
        exp_rv  = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    // One clock of requests: check strobes mid-cycle, then state after the edge.
    task automatic step(input logic p, input logic o, input logic f, input logic [31:0] d);
        logic pop_ok;
        logic push_ok;
        @(negedge clk);
        bus.push  = p;
        bus.pop   = o;
        bus.flush = f;
        wdata     = d;
        pop_ok  = o && (q.size() > 0) && !f;
        push_ok = p && ((q.size() < DEPTH) || pop_ok) && !f;
        #1;
        chk("mem_we", 32'(bus.mem_we), 32'(push_ok));
        chk("mem_re", 32'(bus.mem_re), 32'(pop_ok));
        @(posedge clk);
        #1;
        if (f) begin
            reset_model();
        end else begin
            if (p && !push_ok) exp_ovf = 1'b1;
            if (o && !pop_ok)  exp_unf = 1'b1;
            exp_rv = pop_ok;
            if (pop_ok) begin
                exp_data = q.pop_front();
                n_pop++;
            end
            if (push_ok) begin
                q.push_back(d);
                n_push++;
            end
        end
        chk_state();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset_model();
        reset     = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
        wdata     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        // 1: reset state
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk_state();
        @(negedge clk);
        reset = 1'b1;

        // 2: fill with 0..15, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 32'(i));
        chk("full_after_16", 32'(bus.full), 32'd1);
        // 3: push alone while full is rejected; push+pop while full both accepted
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_0011);
        chk("count_full_stays", 32'(bus.count), 32'd16);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0010);
        chk("rdata_full_pushpop", rdata, 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("empty_after_drain", 32'(bus.empty), 32'd1);

        // 4: push+pop on empty -> push only; pop on empty -> no strobe
        step(1'b1, 1'b1, 1'b0, 32'h0000_00A5);
        chk("pushpop_empty_rv", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);

        // 5: interleaved traffic holding occupancy 3..5, pointers wrap
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < 40; i++) begin
            if (q.size() <= 3)      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, $urandom);
            else if (q.size() >= 5) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom);
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom);
        end

        // 6: flush with push at count 7
        step(1'b1, 1'b1, 1'b1, 32'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b0, 1'b1, $urandom);

        // random traffic with rare flushes
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
                 1'($urandom_range(0, 39) == 0), $urandom);

        // async reset mid-pop drops the in-flight rd_valid immediately
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        reset_model();
        chk("async_rst_rv", 32'(bus.rd_valid), 32'd0);
        chk_state();
        @(negedge clk);
        reset     = 1'b1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h1234_5678);
        step(1'b0, 1'b1, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
